// File: rtl/branch_cmp_pkg.sv
// rtl/branch_cmp_pkg.sv - shared types and funct3 helpers for the serial branch comparator
package branch_cmp_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_signed(input logic [2:0] f3);
        return (f3 == BLT) || (f3 == BGE);
    endfunction

    function automatic logic is_legal(input logic [2:0] f3);
        return !((f3 == 3'b010) || (f3 == 3'b011));
    endfunction

    // Illegal encodings never take the branch.
    function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
        logic t;
        t = 1'b0;
        case (f3)
            BEQ:        t = eq;
            BNE:        t = !eq;
            BLT, BLTU:  t = lt;
            BGE, BGEU:  t = !lt;
            default:    t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_compare_serial_cmp_bit_step.sv
// rtl/branch_compare_serial_cmp_bit_step.sv - one LSB-first compare step: a differing bit overrides the flags
module cmp_bit_step (
    input  logic a,
    input  logic b,
    input  logic gt_in,
    input  logic eq_in,
    input  logic lt_in,
    output logic gt_out,
    output logic eq_out,
    output logic lt_out
);

    logic diff;

    assign diff   = a ^ b;
    assign gt_out = (a & ~b) | (~diff & gt_in);
    assign lt_out = (~a & b) | (~diff & lt_in);
    assign eq_out = ~diff & eq_in;

endmodule

// File: rtl/branch_compare_serial.sv
// rtl/branch_compare_serial.sv - bit-serial RISC-V branch condition unit with valid/ready result
module branch_compare_serial
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             taken_o,
    output logic             eq_o,
    output logic             lt_o,
    output logic             gt_o,
    output logic             err_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       f3_q;
    logic             eq_q, gt_q, lt_q;

    logic bit_a, bit_b;
    logic step_gt, step_eq, step_lt;
    logic nx_gt, nx_eq, nx_lt;

    assign bit_a = a_q[cnt];
    assign bit_b = b_q[cnt];

    cmp_bit_step u_step (
        .a      (bit_a),
        .b      (bit_b),
        .gt_in  (gt_q),
        .eq_in  (eq_q),
        .lt_in  (lt_q),
        .gt_out (step_gt),
        .eq_out (step_eq),
        .lt_out (step_lt)
    );

    // The MSB is the sign bit for signed compares, so a difference there inverts the order.
    always_comb begin
        nx_gt = step_gt;
        nx_lt = step_lt;
        nx_eq = step_eq;
        if (is_signed(f3_q) && (cnt == LAST) && (bit_a != bit_b)) begin
            nx_gt = step_lt;
            nx_lt = step_gt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            taken_o <= 1'b0;
            eq_o    <= 1'b0;
            lt_o    <= 1'b0;
            gt_o    <= 1'b0;
            err_o   <= 1'b0;
        end else if (flush_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            taken_o <= 1'b0;
            eq_o    <= 1'b0;
            lt_o    <= 1'b0;
            gt_o    <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= rs1_i;
                        b_q     <= rs2_i;
                        f3_q    <= funct3_i;
                        eq_q    <= 1'b1;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    eq_q <= nx_eq;
                    gt_q <= nx_gt;
                    lt_q <= nx_lt;
                    if (cnt == LAST) begin
                        state   <= DONE;
                        valid_o <= 1'b1;
                        eq_o    <= nx_eq;
                        gt_o    <= nx_gt;
                        lt_o    <= nx_lt;
                        taken_o <= taken_of(f3_q, nx_eq, nx_lt);
                        err_o   <= !is_legal(f3_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        valid_o <= 1'b0;
                        taken_o <= 1'b0;
                        eq_o    <= 1'b0;
                        lt_o    <= 1'b0;
                        gt_o    <= 1'b0;
                        err_o   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_compare_serial.sv
// tb/tb_branch_compare_serial.sv - randomized self-checking bench for branch_compare_serial
module tb_branch_compare_serial;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  rs1 = '0, rs2 = '0;
    logic [2:0]    f3 = '0;
    logic          flush = 1'b0;
    logic          rdy_in = 1'b0;
    logic          ready, valid, taken, eq, lt, gt, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_compare_serial #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .funct3_i (f3),
        .flush_i  (flush),
        .ready_o  (ready),
        .valid_o  (valid),
        .ready_i  (rdy_in),
        .taken_o  (taken),
        .eq_o     (eq),
        .lt_o     (lt),
        .gt_o     (gt),
        .err_o    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: compare whole operands with plain arithmetic.
    function automatic logic [4:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        logic sgn, m_eq, m_lt, m_gt, m_tk, m_err;
        sgn   = (f == 3'b100) || (f == 3'b101);
        m_eq  = (a == b);
        m_lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
        m_gt  = !m_eq && !m_lt;
        m_err = (f == 3'b010) || (f == 3'b011);
        case (f)
            3'b000:         m_tk = m_eq;
            3'b001:         m_tk = !m_eq;
            3'b100, 3'b110: m_tk = m_lt;
            3'b101, 3'b111: m_tk = !m_lt;
            default:        m_tk = 1'b0;
        endcase
        return {m_tk, m_eq, m_lt, m_gt, m_err};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_outs"}, {valid, taken, eq, lt, gt, err}, 0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                         input int hold, input bit poke_start);
        logic [4:0] exp;
        int cyc;
        exp = model(a, b, f);
        @(negedge clk);
        check("ready_before", ready, 1);
        rs1 = a; rs2 = b; f3 = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; f3 = 3'($urandom);
        cyc = 0;
        while (!valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, W);
        if (cyc >= 100) return;
        check("result", {taken, eq, lt, gt, err}, exp);
        for (int i = 0; i < hold; i++) begin
            start = poke_start && (i == 1);
            @(negedge clk);
            check("hold_result", {valid, taken, eq, lt, gt, err}, {1'b1, exp});
            check("hold_ready", ready, 0);
        end
        start = poke_start;
        rdy_in = 1'b1;
        @(negedge clk);
        rdy_in = 1'b0;
        start = 1'b0;
        check("release", {valid, ready}, 2'b01);
    endtask

    task automatic abort_test(input bit use_rst);
        int seen;
        @(negedge clk);
        rs1 = $urandom; rs2 = $urandom; f3 = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        check_idle(use_rst ? "abort_rst" : "abort_flush");
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("no_valid_after_abort", seen, 0);
        do_op(32'h1234_5678, 32'h1234_5679, 3'b110, 0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic [2:0] f;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0, 1'b0);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 0, 1'b0);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 0, 1'b0);
        do_op(32'h0000_0001, 32'h0000_0000, 3'b001, 0, 1'b0);
        do_op(32'h0000_0005, 32'h0000_0009, 3'b100, 5, 1'b1);
        do_op(32'h0000_0005, 32'h0000_0009, 3'b111, 0, 1'b0);
        abort_test(1'b0);
        abort_test(1'b1);
        do_op($urandom, $urandom, 3'b010, 0, 1'b0);
        do_op(32'hCAFE_0000, 32'hCAFE_0000, 3'b000, 0, 1'b0);
        do_op(32'h0000_0002, 32'h0000_0001, 3'b011, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'h1 << $urandom_range(0, W - 1));
                2:       b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            f = 3'($urandom);
            do_op(a, b, f, $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_compare_serial.md
Name: branch_compare_serial

Overview:
- Multi-cycle, bit-serial branch-condition unit. It consumes RISC-V branch operands and funct3 and produces a taken/not-taken decision through a valid/ready handshake.
- Each cycle it applies the greater/equal/lesser cascade rule to one bit, walking LSB to MSB.
- Area-reduced alternative to the full-width combinational comparator chain. Sits between the register-file read and the PC-select logic.

Parameters:
- WIDTH, 32, operand width in bits; legal values ≥ 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; accepted only when ready_o=1.
- rs1_i  in  WIDTH  operand A; captured on accept.
- rs2_i  in  WIDTH  operand B; captured on accept.
- funct3_i  in  3  branch type; captured on accept.
- flush_i  in  1  abort the current operation; return to IDLE.
- ready_o  out  1  high in IDLE only.
- valid_o  out  1  result available; held until ready_i.
- ready_i  in  1  downstream accepts the result.
- taken_o  out  1  branch decision; meaningful only while valid_o=1.
- eq_o / lt_o / gt_o  out  1 each  final compare flags, signedness applied.
- err_o  out  1  funct3 was illegal (010 or 011).

Behaviour:
- Reset values:
  - rst_i=1 at an edge forces state IDLE, bit counter 0, and flags eq=1, gt=0, lt=0.
  - Outputs after reset: valid_o=0, taken_o=0, err_o=0, eq_o=0, lt_o=0, gt_o=0, ready_o=1.
  - Reset in any state, including mid-RUN, aborts the operation with no valid_o pulse.
- Precedence at an edge: rst_i, then flush_i, then normal operation.
- States and transitions:
  - IDLE: if start_i=1, capture rs1, rs2, funct3; set flags eq=1/gt=0/lt=0 and cnt=0; go to RUN.
  - RUN: process bit cnt each cycle.
    - If a[cnt]≠b[cnt]: gt=a[cnt]&~b[cnt], lt=~a[cnt]&b[cnt], eq=0.
    - Otherwise the flags are kept.
    - Signed funct3 (BLT/BGE) at cnt=WIDTH-1 with differing bits: gt and lt are swapped, because the MSB is the sign.
    - After cnt=WIDTH-1, go to DONE; otherwise cnt+1.
  - DONE: valid_o=1 with registered taken_o, flags and err_o. If ready_i=1, go to IDLE; otherwise hold with all outputs stable.
  - flush_i=1 in RUN or DONE: go to IDLE at that edge; valid_o=0 the next cycle; the result is discarded.
- Latency:
  - Start accepted at edge k; valid_o first seen high after edge k+WIDTH, i.e. WIDTH cycles.
  - Minimum issue interval is WIDTH+2 cycles: RUN, then DONE, then IDLE before the next start.
- Decision table (flags are final):
  - BEQ 000 = eq; BNE 001 = ~eq.
  - BLT 100 = lt; BGE 101 = ~lt.
  - BLTU 110 = lt; BGEU 111 = ~lt.
  - 010/011: taken=0, err=1; the compare still runs to completion.
- Boundaries and simultaneous events:
  - start_i while ready_o=0 is ignored, not queued.
  - DONE with ready_i=1 and start_i=1 in the same cycle: the start is ignored; it is accepted the following cycle in IDLE.
  - Operand inputs may change after accept; only the captured copies are used.
  - Counter width is $clog2(WIDTH). It never wraps: the transition to DONE occurs at WIDTH-1.
- Output encoding:
  - eq_o, lt_o, gt_o are one-hot in DONE.
  - All outputs are registered; there are no combinational input-to-output paths except none.

Decomposition:
- Package branch_cmp_pkg holds:
  - typedef enum logic [2:0] for funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - typedef enum logic [1:0] state_t (IDLE, RUN, DONE);
  - function is_signed(funct3) and function is_legal(funct3).
- Sub-module cmp_bit_step: the combinational per-bit flag update (a, b, gt/eq/lt in → gt/eq/lt out), built from the codebase's and/or/xor gate cells.
  - It is instantiated once and fed from the flag registers.
  - The signed swap is done in the top module.

Test Plan:
1. BEQ, rs1=rs2=0xDEADBEEF → valid_o rises exactly 32 cycles after accept; taken_o=1, eq_o=1, err_o=0.
2. BLT, rs1=0xFFFFFFFF, rs2=0x00000001 → taken_o=1, lt_o=1. Same operands with BLTU → taken_o=0, gt_o=1.
3. BGE, rs1=0x80000000, rs2=0x7FFFFFFF → taken_o=0. BGEU → taken_o=1. BNE, rs1=0x1, rs2=0x0 → taken_o=1.
4. ready_i held low for 5 cycles in DONE; start_i pulsed meanwhile:
   - valid_o, taken_o and flags are stable throughout;
   - the start is ignored;
   - after ready_i=1, ready_o=1 the next cycle, and a new start is accepted.
5. flush_i asserted 10 cycles into RUN → IDLE at that edge; no valid_o pulse; a start the following cycle completes normally. Repeat the same check with rst_i instead of flush_i, confirming all outputs return to their reset values.
6. funct3=3'b010, any operands → valid_o after 32 cycles with taken_o=0, err_o=1. The back-to-back BEQ that follows reports err_o=0.
